// File: rtl/botoes_led_debounce.sv
// botoes_led_debounce
//   N push buttons are synchronised and debounced. Their stable levels are
//   combined by a selectable mode (OR / AND / XOR / TOGGLE) and the result is
//   registered onto the LED pin pino13.
//
//   Optional feature macro: CONTADOR_PRESSOES_EN. When it is defined, the
//   contagem port exists and counts debounced presses.
//
// Ports
//   clk              in   1          system clock, rising edge
//   rst              in   1          synchronous reset, active-high
//   botoes           in   N_BOTOES   raw asynchronous buttons, 1 = pressed
//   modo             in   2          00 OR, 01 AND, 10 TOGGLE, 11 XOR
//   pino13           out  1          LED, 1 = on
//   botoes_estaveis  out  N_BOTOES   debounced button levels
//   borda_subida     out  1          1-cycle pulse when any debounced channel rose
//   contagem         out  LARG_CONT  debounced press count (CONTADOR_PRESSOES_EN only)
module botoes_led_debounce #(
    parameter int N_BOTOES        = 2,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int LARG_CONT       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BOTOES-1:0]  botoes,
    input  logic [1:0]           modo,
    output logic                 pino13,
    output logic [N_BOTOES-1:0]  botoes_estaveis,
`ifdef CONTADOR_PRESSOES_EN
    output logic [LARG_CONT-1:0] contagem,
`endif
    output logic                 borda_subida
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        MODO_OR  = 2'b00,
        MODO_AND = 2'b01,
        MODO_TGL = 2'b10,
        MODO_XOR = 2'b11
    } modo_e;

    logic [N_BOTOES-1:0]         sinc1_q, sinc1_d;
    logic [N_BOTOES-1:0]         sinc2_q, sinc2_d;
    logic [N_BOTOES-1:0]         estavel_q, estavel_d;
    logic [N_BOTOES-1:0]         estavel_ant_q, estavel_ant_d;
    logic [N_BOTOES-1:0][CW-1:0] cnt_q, cnt_d;
    modo_e                       modo_ant_q, modo_ant_d;
    logic                        tgl_q, tgl_d;
    logic                        pino13_q, pino13_d;
    logic                        borda_q, borda_d;
    logic                        subida;
    modo_e                       modo_atual;
`ifdef CONTADOR_PRESSOES_EN
    logic [LARG_CONT-1:0]        contagem_q, contagem_d;
`endif

    assign modo_atual = modo_e'(modo);

    always_comb begin
        sinc1_d       = botoes;
        sinc2_d       = sinc1_q;
        estavel_d     = estavel_q;
        cnt_d         = cnt_q;
        estavel_ant_d = estavel_q;
        modo_ant_d    = modo_atual;

        // Per channel: count consecutive cycles where the synchronised level
        // disagrees with the stable one; accept it after DEBOUNCE_CICLOS.
        for (int i = 0; i < N_BOTOES; i++) begin
            if (sinc2_q[i] == estavel_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                estavel_d[i] = sinc2_q[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        // One pulse no matter how many channels rose together.
        subida  = |(estavel_q & ~estavel_ant_q);
        borda_d = subida;

        // Entering TOGGLE forces a known-off state and swallows a rise
        // arriving on the same edge.
        tgl_d = tgl_q;
        if (modo_atual == MODO_TGL && modo_ant_q != MODO_TGL) begin
            tgl_d = 1'b0;
        end else if (subida) begin
            tgl_d = ~tgl_q;
        end

        pino13_d = 1'b0;
        case (modo_atual)
            MODO_OR:  pino13_d = |estavel_q;
            MODO_AND: pino13_d = &estavel_q;
            MODO_XOR: pino13_d = ^estavel_q;
            MODO_TGL: pino13_d = tgl_d;
            default:  pino13_d = 1'b0;
        endcase

`ifdef CONTADOR_PRESSOES_EN
        contagem_d = contagem_q + LARG_CONT'(subida);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sinc1_q       <= '0;
            sinc2_q       <= '0;
            estavel_q     <= '0;
            estavel_ant_q <= '0;
            cnt_q         <= '0;
            modo_ant_q    <= MODO_OR;
            tgl_q         <= 1'b0;
            pino13_q      <= 1'b0;
            borda_q       <= 1'b0;
`ifdef CONTADOR_PRESSOES_EN
            contagem_q    <= '0;
`endif
        end else begin
            sinc1_q       <= sinc1_d;
            sinc2_q       <= sinc2_d;
            estavel_q     <= estavel_d;
            estavel_ant_q <= estavel_ant_d;
            cnt_q         <= cnt_d;
            modo_ant_q    <= modo_ant_d;
            tgl_q         <= tgl_d;
            pino13_q      <= pino13_d;
            borda_q       <= borda_d;
`ifdef CONTADOR_PRESSOES_EN
            contagem_q    <= contagem_d;
`endif
        end
    end

    assign pino13          = pino13_q;
    assign botoes_estaveis = estavel_q;
    assign borda_subida    = borda_q;
`ifdef CONTADOR_PRESSOES_EN
    assign contagem        = contagem_q;
`endif

endmodule

// File: tb/tb_botoes_led_debounce.sv
// Bench for botoes_led_debounce: directed steps plus random button activity,
// all outputs compared every cycle against a queue-based reference model.
module tb_botoes_led_debounce;
    localparam int N = 2;
    localparam int D = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] botoes = '1;
    logic [1:0]   modo = 2'b00;
    logic         pino13;
    logic [N-1:0] botoes_estaveis;
    logic         borda_subida;
    logic [W-1:0] contagem;

    int nerr = 0;
    int nchk = 0;

    botoes_led_debounce #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D), .LARG_CONT(W)) dut (
        .clk(clk),
        .rst(rst),
        .botoes(botoes),
        .modo(modo),
        .pino13(pino13),
        .botoes_estaveis(botoes_estaveis),
`ifdef CONTADOR_PRESSOES_EN
        .contagem(contagem),
`endif
        .borda_subida(borda_subida)
    );

`ifndef CONTADOR_PRESSOES_EN
    assign contagem = '0;
`endif

    always #5 clk = ~clk;

    // Reference model. hist[k] holds the raw input sampled k edges ago
    // (hist[0] = this edge); a level reaches the synchroniser output two
    // edges after sampling, so the debounce window is hist[2..D+1].
    logic [N-1:0] hist[$];
    logic [N-1:0] m_est = '0;
    logic         m_rise_last = 1'b0;
    logic         m_pino = 1'b0;
    logic         m_borda = 1'b0;
    logic         m_tgl = 1'b0;
    logic [1:0]   m_modo_ant = 2'b00;
    logic [W-1:0] m_cnt = '0;

    always @(posedge clk) begin
        logic [N-1:0] novo;
        logic         igual;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
            m_est = '0; m_rise_last = 0; m_pino = 0; m_borda = 0;
            m_tgl = 0; m_modo_ant = 2'b00; m_cnt = '0;
        end else begin
            if (hist.size() == 0)
                for (int k = 0; k < D + 2; k++) hist.push_back('0);
            hist.push_front(botoes);
            void'(hist.pop_back());
            m_borda = m_rise_last;
            m_cnt   = m_cnt + W'(m_rise_last);
            case (modo)
                2'b00: m_pino = (m_est != 0);
                2'b01: m_pino = (m_est == {N{1'b1}});
                2'b11: m_pino = ($countones(m_est) % 2) == 1;
                default: begin
                    if (m_modo_ant != 2'b10) m_tgl = 1'b0;
                    else if (m_rise_last)    m_tgl = ~m_tgl;
                    m_pino = m_tgl;
                end
            endcase
            m_modo_ant = modo;
            novo = m_est;
            for (int c = 0; c < N; c++) begin
                igual = 1'b1;
                for (int k = 3; k <= D + 1; k++)
                    if (hist[k][c] != hist[2][c]) igual = 1'b0;
                if (igual && hist[2][c] != m_est[c]) novo[c] = hist[2][c];
            end
            m_rise_last = |(novo & ~m_est);
            m_est = novo;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("pino13", 32'(pino13), 32'(m_pino));
        chk("estaveis", 32'(botoes_estaveis), 32'(m_est));
        chk("borda", 32'(borda_subida), 32'(m_borda));
`ifdef CONTADOR_PRESSOES_EN
        chk("contagem", 32'(contagem), 32'(m_cnt));
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [3:0]   t_or, t_and, t_xor, tbl;
        logic [W-1:0] c0;
        t_or = 4'b1110; t_and = 4'b1000; t_xor = 4'b0110;

        // 1. reset with both buttons held
        steps(2);
        chk("rst_pino", 32'(pino13), 0);
        chk("rst_est", 32'(botoes_estaveis), 0);
        chk("rst_borda", 32'(borda_subida), 0);
`ifdef CONTADOR_PRESSOES_EN
        chk("rst_cont", 32'(contagem), 0);
`endif
        rst = 0;
        steps(5);
        chk("lat_hold_est", 32'(botoes_estaveis), 0);
        chk("lat_hold_pino", 32'(pino13), 0);
        step();
        chk("lat_est11", 32'(botoes_estaveis), 3);
        step();
        chk("lat_pino11", 32'(pino13), 1);

        // 2. OR latency for 00 -> 01
        botoes = 2'b00; steps(10);
        botoes = 2'b01;
        steps(5);
        chk("e5_est", 32'(botoes_estaveis), 0);
        step();
        chk("e6_est", 32'(botoes_estaveis), 1);
        chk("e6_pino", 32'(pino13), 0);
        step();
        chk("e7_pino", 32'(pino13), 1);
        chk("e7_borda", 32'(borda_subida), 1);
`ifdef CONTADOR_PRESSOES_EN
        chk("e7_cont", 32'(contagem), 2);
`endif
        step();
        chk("e8_borda", 32'(borda_subida), 0);

        // truth tables
        for (int m = 0; m < 3; m++) begin
            modo = (m == 0) ? 2'b00 : (m == 1) ? 2'b01 : 2'b11;
            tbl  = (m == 0) ? t_or : (m == 1) ? t_and : t_xor;
            for (int v = 0; v < 4; v++) begin
                botoes = 2'(v);
                steps(9);
                chk("tabela", 32'(pino13), 32'(tbl[v]));
            end
        end

        // 3. glitch of 3 cycles is filtered
        modo = 2'b00; botoes = 2'b00; steps(9);
        c0 = m_cnt;
        botoes = 2'b01; steps(3);
        botoes = 2'b00;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("glitch_est", 32'(botoes_estaveis), 0);
            chk("glitch_borda", 32'(borda_subida), 0);
            chk("glitch_pino", 32'(pino13), 0);
        end
`ifdef CONTADOR_PRESSOES_EN
        chk("glitch_cont", 32'(contagem), 32'(c0));
`endif

        // 4. toggle
        modo = 2'b10; steps(2);
        chk("tgl_ini", 32'(pino13), 0);
        c0 = m_cnt;
        botoes = 2'b01; steps(9);
        chk("tgl_p1", 32'(pino13), 1);
        botoes = 2'b00; steps(9);
        chk("tgl_r1", 32'(pino13), 1);
        botoes = 2'b01; steps(9);
        chk("tgl_p2", 32'(pino13), 0);
        botoes = 2'b00; steps(9);
`ifdef CONTADOR_PRESSOES_EN
        chk("tgl_cont2", 32'(contagem), 32'(W'(c0 + 2)));
`endif
        botoes = 2'b11; steps(9);
        chk("tgl_both", 32'(pino13), 1);
`ifdef CONTADOR_PRESSOES_EN
        chk("tgl_cont3", 32'(contagem), 32'(W'(c0 + 3)));
`endif
        botoes = 2'b00; steps(9);

        // 5. switching into TOGGLE clears the LED
        modo = 2'b00; botoes = 2'b01; steps(9);
        chk("sw_or", 32'(pino13), 1);
        modo = 2'b10; step();
        chk("sw_tgl", 32'(pino13), 0);
        // rise arriving exactly on the switch edge is ignored
        modo = 2'b00; botoes = 2'b00; steps(9);
        botoes = 2'b10; steps(6);
        modo = 2'b10; step();
        chk("sw_rise_pino", 32'(pino13), 0);
        chk("sw_rise_borda", 32'(borda_subida), 1);
        steps(4);
        // reset mid-debounce discards the pending change
        modo = 2'b00; botoes = 2'b00; steps(9);
        botoes = 2'b01; steps(4);
        rst = 1; step();
        rst = 0; botoes = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_rst_est", 32'(botoes_estaveis), 0);
        end

        // random activity
        for (int i = 0; i < 300; i++) begin
            botoes = N'($urandom);
            if ($urandom_range(0, 7) == 0) modo = 2'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1; step(); rst = 0;
            end
            steps($urandom_range(1, 8));
        end

        // 6. counter wrap after 256 presses
        rst = 1; botoes = 2'b00; modo = 2'b00; step();
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            botoes = 2'b01; steps(6);
            botoes = 2'b00; steps(6);
        end
        steps(2);
`ifdef CONTADOR_PRESSOES_EN
        chk("wrap", 32'(contagem), 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
